conv_window_feeder: RTL and testbench

- Initiator side of the convolution-engine window interface: owns the image and kernel storage and sequences the engine through every valid window position.
- A host loads the image and kernel, then pulses i_go.
- The block emits a start strobe and streams paired window pixels plus kernel taps, one per beat, to the engine.
- It captures the two engine results per job, publishes each as it arrives, and pulses o_done when the image is finished.

---
 rtl/conv_window_feeder_pkg.sv | 30 +++
 rtl/conv_window_addr_gen.sv | 78 +++++++
 rtl/conv_window_feeder.sv | 197 +++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the convolution window feeder:
// FSM states, default geometry and store-select encodings.
package conv_window_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4,
    FIN    = 3'd5
  } feeder_state_e;

  localparam int DEF_KERNEL_SIZE = 32'sd3;
  localparam int DEF_IMG_W       = 32'sd4;
  localparam int OUT_W           = DEF_IMG_W - DEF_KERNEL_SIZE + 32'sd1;
  localparam int TAPS            = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

  localparam logic SEL_IMAGE  = 1'b0;
  localparam logic SEL_KERNEL = 1'b1;

  function automatic int calc_out_w(input int img_w, input int k);
    return img_w - k + 32'sd1;
  endfunction

  function automatic int calc_taps(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window position (row/col) and in-kernel beat (krow/kcol) counters plus
// the pixel / tap address arithmetic for the paired left/right windows.
module conv_window_addr_gen
  import conv_window_feeder_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int ADDR_WIDTH  = 32'sd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat_adv,
  input  logic                  job_adv,
  output logic [ADDR_WIDTH-1:0] w1_addr,
  output logic [ADDR_WIDTH-1:0] w2_addr,
  output logic [ADDR_WIDTH-1:0] tap_idx,
  output logic [ADDR_WIDTH-1:0] idx_base,
  output logic                  last_beat,
  output logic                  last_job
);

  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(32'd2);
  localparam logic [ADDR_WIDTH-1:0] K_N      = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(KERNEL_SIZE - 32'sd1);
  localparam logic [ADDR_WIDTH-1:0] IMG_N    = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] OUT_N    = ADDR_WIDTH'(calc_out_w(IMG_W, KERNEL_SIZE));

  logic [ADDR_WIDTH-1:0] row_r;
  logic [ADDR_WIDTH-1:0] col_r;
  logic [ADDR_WIDTH-1:0] krow_r;
  logic [ADDR_WIDTH-1:0] kcol_r;

  // Position and beat counters; columns advance in pairs since each job covers two windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r  <= '0;
      col_r  <= '0;
      krow_r <= '0;
      kcol_r <= '0;
    end else if (clr) begin
      row_r  <= '0;
      col_r  <= '0;
      krow_r <= '0;
      kcol_r <= '0;
    end else if (job_adv) begin
      krow_r <= '0;
      kcol_r <= '0;
      if (col_r + COL_STEP == OUT_N) begin
        col_r <= '0;
        row_r <= row_r + ONE;
      end else begin
        col_r <= col_r + COL_STEP;
      end
    end else if (beat_adv) begin
      if (kcol_r == K_LAST) begin
        kcol_r <= '0;
        krow_r <= krow_r + ONE;
      end else begin
        kcol_r <= kcol_r + ONE;
      end
    end else begin
      row_r <= row_r;
    end
  end

  // Address arithmetic from the counters
  always_comb begin
    w1_addr   = (row_r + krow_r) * IMG_N + col_r + kcol_r;
    w2_addr   = w1_addr + ONE;
    tap_idx   = krow_r * K_N + kcol_r;
    idx_base  = row_r * OUT_N + col_r;
    last_beat = (krow_r == K_LAST) && (kcol_r == K_LAST);
    last_job  = (col_r + COL_STEP == OUT_N) && (row_r + ONE == OUT_N);
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Convolution engine initiator: holds image/kernel storage, walks every
// window pair through the engine and publishes the returned results.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int KERNEL_SIZE     = DEF_KERNEL_SIZE,
  parameter int DATA_WIDTH      = 32'sd8,
  parameter int SRAM_ADDR_WIDTH = 32'sd4,
  parameter int SRAM_DEPTH      = 32'sd16,
  parameter int IMG_W           = DEF_IMG_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic                       i_wr_sel,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_go,
  output logic                       o_conv_start,
  output logic [SRAM_ADDR_WIDTH-1:0] o_window1_addr,
  output logic [DATA_WIDTH-1:0]      o_window1_data,
  output logic [SRAM_ADDR_WIDTH-1:0] o_window2_addr,
  output logic [DATA_WIDTH-1:0]      o_window2_data,
  output logic [DATA_WIDTH-1:0]      o_kernel_data,
  input  logic [DATA_WIDTH-1:0]      i_conv_result,
  input  logic                       i_conv_done,
  output logic                       o_res_valid,
  output logic [SRAM_ADDR_WIDTH-1:0] o_res_idx,
  output logic [DATA_WIDTH-1:0]      o_res_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int TAP_CNT = calc_taps(KERNEL_SIZE);
  localparam logic [SRAM_ADDR_WIDTH-1:0] KERN_N = SRAM_ADDR_WIDTH'(TAP_CNT);

  feeder_state_e state_r;
  feeder_state_e state_s;

  logic [DATA_WIDTH-1:0]      img_mem_r  [SRAM_DEPTH];
  logic [DATA_WIDTH-1:0]      kern_mem_r [TAP_CNT];
  logic                       clr_s;
  logic                       beat_adv_s;
  logic                       job_adv_s;
  logic                       win_en_s;
  logic [SRAM_ADDR_WIDTH-1:0] w1_addr_s;
  logic [SRAM_ADDR_WIDTH-1:0] w2_addr_s;
  logic [SRAM_ADDR_WIDTH-1:0] tap_idx_s;
  logic [SRAM_ADDR_WIDTH-1:0] idx_base_s;
  logic                       last_beat_s;
  logic                       last_job_s;
  logic                       res_cnt_r;
  logic                       start_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       res_valid_r;
  logic [SRAM_ADDR_WIDTH-1:0] res_idx_r;
  logic [DATA_WIDTH-1:0]      res_data_r;

  conv_window_addr_gen #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_W       (IMG_W),
    .ADDR_WIDTH  (SRAM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (clr_s),
    .beat_adv  (beat_adv_s),
    .job_adv   (job_adv_s),
    .w1_addr   (w1_addr_s),
    .w2_addr   (w2_addr_s),
    .tap_idx   (tap_idx_s),
    .idx_base  (idx_base_s),
    .last_beat (last_beat_s),
    .last_job  (last_job_s)
  );

  // Host writes land only while idle; storage is deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (state_r == IDLE)) begin
      if (i_wr_sel == SEL_IMAGE) begin
        img_mem_r[i_wr_addr] <= i_wr_data;
      end else if (i_wr_addr < KERN_N) begin
        kern_mem_r[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and counter controls; START does not advance so beat 0 repeats in STREAM
  always_comb begin
    state_s    = state_r;
    clr_s      = 1'b0;
    beat_adv_s = 1'b0;
    job_adv_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_go) begin
          state_s = START;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START:  state_s = STREAM;
      STREAM: begin
        if (last_beat_s) begin
          state_s = WAIT;
        end else begin
          beat_adv_s = 1'b1;
        end
      end
      WAIT: begin
        if (i_conv_done && res_cnt_r) begin
          state_s = NEXT;
        end else begin
          state_s = WAIT;
        end
      end
      NEXT: begin
        job_adv_s = 1'b1;
        if (last_job_s) begin
          state_s = FIN;
        end else begin
          state_s = START;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered strobes aligned with the state they describe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      start_r <= (state_s == START);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == FIN);
    end
  end

  // Result capture: first engine result is the left window, second the right
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_cnt_r   <= 1'b0;
      res_valid_r <= 1'b0;
      res_idx_r   <= '0;
      res_data_r  <= '0;
    end else begin
      res_valid_r <= 1'b0;
      if ((state_r == WAIT) && i_conv_done) begin
        res_valid_r <= 1'b1;
        res_idx_r   <= idx_base_s + {{(SRAM_ADDR_WIDTH-1){1'b0}}, res_cnt_r};
        res_data_r  <= i_conv_result;
        res_cnt_r   <= ~res_cnt_r;
      end
    end
  end

  // Window outputs are live only while a job is being presented, zero otherwise
  always_comb begin
    win_en_s = (state_r == START) || (state_r == STREAM) || (state_r == WAIT);
    if (win_en_s) begin
      o_window1_addr = w1_addr_s;
      o_window2_addr = w2_addr_s;
      o_window1_data = img_mem_r[w1_addr_s];
      o_window2_data = img_mem_r[w2_addr_s];
      o_kernel_data  = kern_mem_r[tap_idx_s];
    end else begin
      o_window1_addr = '0;
      o_window2_addr = '0;
      o_window1_data = '0;
      o_window2_data = '0;
      o_kernel_data  = '0;
    end
  end

  assign o_conv_start = start_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_res_valid  = res_valid_r;
  assign o_res_idx    = res_idx_r;
  assign o_res_data   = res_data_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: a timed engine model and a
// reference of window geometry computed directly from (row, col, beat).
module tb_conv_window_feeder;

  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int IMGW  = 4;
  localparam int OUTW  = IMGW - K + 1;
  localparam int TAPS  = K * K;
  localparam int JOBS  = OUTW * OUTW / 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr_en = 1'b0;
  logic          i_wr_sel = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_go = 1'b0;
  logic [DW-1:0] i_conv_result = '0;
  logic          i_conv_done = 1'b0;
  logic          o_conv_start, o_res_valid, o_busy, o_done;
  logic [AW-1:0] o_window1_addr, o_window2_addr, o_res_idx;
  logic [DW-1:0] o_window1_data, o_window2_data, o_kernel_data, o_res_data;
  logic [47:0]   all_outs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] img_m  [DEPTH];
  logic [DW-1:0] kern_m [TAPS];

  conv_window_feeder #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW),
    .SRAM_DEPTH(DEPTH), .IMG_W(IMGW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_go(i_go),
    .o_conv_start(o_conv_start),
    .o_window1_addr(o_window1_addr), .o_window1_data(o_window1_data),
    .o_window2_addr(o_window2_addr), .o_window2_data(o_window2_data),
    .o_kernel_data(o_kernel_data),
    .i_conv_result(i_conv_result), .i_conv_done(i_conv_done),
    .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_data(o_res_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  assign all_outs = {o_conv_start, o_window1_addr, o_window1_data, o_window2_addr,
                     o_window2_data, o_kernel_data, o_res_valid, o_res_idx,
                     o_res_data, o_busy, o_done};

  always #5 i_clk = ~i_clk;

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (all_outs !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (all_outs !== 48'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs);
    end
  endtask

  // Runs a whole image; optional reload (last write shares its cycle with go),
  // engine latency, fixed 0x11/0x22 results, and disturbances while busy.
  task automatic test_image(input bit reload, input bit ramp, input int lat,
                            input bit fixed_res, input bit noise);
    int cyc = -1;
    int starts = 0;
    int dones = 0;
    int nres = 0;
    int done_at = -1;
    int j, r, c, k, a1;
    logic [DW-1:0] rv;
    logic [AW-1:0] q_idx[$];
    logic [DW-1:0] q_dat[$];
    logic [AW-1:0] e_idx;
    logic [DW-1:0] e_dat;
    logic [43:0]   exp_w, obs_w;

    if (reload) begin
      for (int t = 0; t < TAPS; t++) begin
        kern_m[t] = ramp ? DW'(t + 1) : DW'($urandom);
        i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_addr = AW'(t); i_wr_data = kern_m[t];
        @(negedge i_clk);
      end
      for (int a = 1; a < DEPTH; a++) begin
        img_m[a] = ramp ? DW'(a) : DW'($urandom);
        i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = AW'(a); i_wr_data = img_m[a];
        @(negedge i_clk);
      end
      img_m[0] = ramp ? DW'(0) : DW'($urandom);
      i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = '0; i_wr_data = img_m[0];
    end
    i_go = 1'b1;
    @(negedge i_clk);

    for (int t = 0; t < 600 && !(done_at >= 0 && t > done_at + 1); t++) begin
      if (o_conv_start) begin
        cyc = 0;
        starts++;
      end else if (cyc >= 0) begin
        cyc++;
      end
      j = starts - 1;
      r = j / (OUTW / 2);
      c = 2 * (j % (OUTW / 2));

      if (cyc >= 0 && cyc <= 10 + lat) begin
        k  = (cyc == 0) ? 0 : ((cyc > TAPS) ? TAPS - 1 : cyc - 1);
        a1 = (r + k / K) * IMGW + c + (k % K);
        exp_w = {AW'(a1), img_m[a1], AW'(a1 + 1), img_m[a1 + 1], kern_m[k]};
        obs_w = {o_window1_addr, o_window1_data, o_window2_addr, o_window2_data, o_kernel_data};
        n_checks++;
        if (obs_w !== exp_w) begin
          n_fail++;
          $display("FAIL beat job%0d k%0d: got %h expected %h", j, k, obs_w, exp_w);
        end
      end

      if (o_res_valid) begin
        nres++;
        n_checks++;
        if (q_idx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got idx %0d data %h expected none", o_res_idx, o_res_data);
        end else begin
          e_idx = q_idx.pop_front();
          e_dat = q_dat.pop_front();
          if ({o_res_idx, o_res_data} !== {e_idx, e_dat}) begin
            n_fail++;
            $display("FAIL result: got idx %0d data %h expected idx %0d data %h",
                     o_res_idx, o_res_data, e_idx, e_dat);
          end
        end
      end

      if (o_done) begin
        dones++;
        done_at = t;
        n_checks++;
        if (o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_at_done: got %b expected 1", o_busy);
        end
      end else if (done_at >= 0 && t == done_at + 1) begin
        n_checks++;
        if (o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_done: got %b expected 0", o_busy);
        end
      end

      i_wr_en = 1'b0; i_go = 1'b0; i_conv_done = 1'b0;
      if (cyc == 9 + lat || cyc == 11 + lat) begin
        if (fixed_res) rv = (cyc == 9 + lat) ? 8'h11 : 8'h22;
        else           rv = DW'($urandom);
        i_conv_done = 1'b1;
        i_conv_result = rv;
        q_idx.push_back(AW'(r * OUTW + c + ((cyc == 11 + lat) ? 1 : 0)));
        q_dat.push_back(rv);
      end
      if (noise) begin
        if (cyc == 3) begin
          i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = '0; i_wr_data = 8'hFF;
        end
        if (cyc == 5) begin
          i_conv_done = 1'b1; i_conv_result = 8'hEE;
        end
        if (cyc == 10) i_go = 1'b1;
      end
      @(negedge i_clk);
    end
    i_wr_en = 1'b0; i_go = 1'b0; i_conv_done = 1'b0;

    n_checks++;
    if (dones != 1 || starts != JOBS || nres != 2 * JOBS || q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL image_totals: got done %0d starts %0d results %0d pending %0d expected 1 %0d %0d 0",
               dones, starts, nres, q_idx.size(), JOBS, 2 * JOBS);
    end
  endtask

  task automatic test_mid_reset();
    i_go = 1'b1;
    @(negedge i_clk);
    i_go = 1'b0;
    repeat (5) @(negedge i_clk);
    n_checks++;
    if (o_window1_addr !== 4'd5 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stream_beat4: got addr %0d busy %b expected 5 1", o_window1_addr, o_busy);
    end
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== 48'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (all_outs !== 48'h0) begin
      n_fail++;
      $display("FAIL idle_after_mid_reset: got %h expected 0", all_outs);
    end
  endtask

  initial begin
    test_reset();
    test_image(1'b1, 1'b1, 1, 1'b1, 1'b0);
    test_image(1'b0, 1'b1, 3, 1'b0, 1'b1);
    test_image(1'b0, 1'b1, 2, 1'b0, 1'b0);
    test_mid_reset();
    test_image(1'b1, 1'b0, 3, 1'b0, 1'b0);
    test_image(1'b0, 1'b0, 4, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
